// File: rtl/i2c_master_byte.sv
// Byte-level I2C master: optional START, 8 data bits, ACK bit, optional STOP; rsp_valid at T+1+N*CLK_DIV.
// Accepts one command at a time (cmd_ready in IDLE/DONE only); SCL/SDA are registered pull-low enables.
module i2c_master_byte #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_start,
  input  logic       cmd_stop,
  input  logic       cmd_read,
  input  logic       cmd_nack,
  input  logic [7:0] wr_data,
  output logic [7:0] rd_data,
  output logic       rsp_valid,
  output logic       rsp_nack,
  output logic       rsp_arb_lost,
  output logic       busy,
  output logic       scl_oe,
  output logic       sda_oe,
  input  logic       sda_in
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_BIT,
    S_ACK,
    S_STOP,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    qtr_q, qtr_d;
  logic [2:0]    bit_q, bit_d;
  logic          stop_q, stop_d;
  logic          read_q, read_d;
  logic          nack_q, nack_d;
  logic [7:0]    wdata_q, wdata_d;
  logic [7:0]    shift_q, shift_d;
  logic          ack_q, ack_d;
  logic [7:0]    rd_data_q, rd_data_d;
  logic          rsp_nack_q, rsp_nack_d;
  logic          arb_q, arb_d;
  logic          scl_oe_q, scl_oe_d;
  logic          sda_oe_q, sda_oe_d;

  logic accept;
  logic phase_last;
  logic sample;
  logic arb_event;
  logic bit_low;
  logic ack_low;

  assign cmd_ready    = (state_q == S_IDLE) || (state_q == S_DONE);
  assign busy         = ~cmd_ready;
  assign rsp_valid    = (state_q == S_DONE);
  assign accept       = cmd_valid && cmd_ready;
  assign phase_last   = (cnt_q == CNT_LAST);
  assign sample       = phase_last && (qtr_q == 2'd2);

  assign rd_data      = rd_data_q;
  assign rsp_nack     = rsp_nack_q;
  assign rsp_arb_lost = arb_q;
  assign scl_oe       = scl_oe_q;
  assign sda_oe       = sda_oe_q;

  // Sequencing: quarter counter, bit index, sampling and result publication.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    qtr_d      = qtr_q;
    bit_d      = bit_q;
    stop_d     = stop_q;
    read_d     = read_q;
    nack_d     = nack_q;
    wdata_d    = wdata_q;
    shift_d    = shift_q;
    ack_d      = ack_q;
    rd_data_d  = rd_data_q;
    rsp_nack_d = rsp_nack_q;
    arb_d      = arb_q;
    arb_event  = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (accept) begin
          state_d    = cmd_start ? S_START : S_BIT;
          cnt_d      = '0;
          qtr_d      = 2'd0;
          bit_d      = 3'd7;
          stop_d     = cmd_stop;
          read_d     = cmd_read;
          nack_d     = cmd_nack;
          wdata_d    = wr_data;
          shift_d    = 8'h00;
          ack_d      = 1'b0;
          rd_data_d  = 8'h00;
          rsp_nack_d = 1'b0;
          arb_d      = 1'b0;
        end else if (state_q == S_DONE) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        cnt_d = phase_last ? '0 : cnt_q + 1'b1;
        if (phase_last) begin
          qtr_d = qtr_q + 1'b1;
        end
        if (sample && (state_q == S_BIT)) begin
          shift_d = {shift_q[6:0], sda_in};
        end
        if (sample && (state_q == S_ACK)) begin
          ack_d = sda_in;
        end

        // Released a 1 but the bus reads 0: another master owns the line.
        if ((state_q == S_BIT) && !read_q && sample && !sda_oe_q && !sda_in) begin
          arb_event = 1'b1;
          state_d   = S_DONE;
          qtr_d     = 2'd0;
          cnt_d     = '0;
        end else if (phase_last && (qtr_q == 2'd3)) begin
          case (state_q)
            S_START: state_d = S_BIT;
            S_BIT: begin
              if (bit_q == 3'd0) begin
                state_d = S_ACK;
              end else begin
                bit_d = bit_q - 1'b1;
              end
            end
            S_ACK:   state_d = stop_q ? S_STOP : S_DONE;
            S_STOP:  state_d = S_DONE;
            default: state_d = S_IDLE;
          endcase
        end

        if (state_d == S_DONE) begin
          rd_data_d  = read_q ? shift_q : 8'h00;
          rsp_nack_d = read_q ? nack_q : ack_q;
          arb_d      = arb_event;
        end
      end
    endcase
  end

  // Line enables are a function of the phase being entered, so they register on phase boundaries.
  always_comb begin
    scl_oe_d = scl_oe_q;
    sda_oe_d = sda_oe_q;
    bit_low  = read_d ? 1'b0 : ~wdata_d[bit_d];
    ack_low  = read_d ? ~nack_d : 1'b0;

    case (state_d)
      S_START: begin
        scl_oe_d = (qtr_d == 2'd0) ? scl_oe_q : (qtr_d == 2'd3);
        sda_oe_d = qtr_d[1];
      end
      S_BIT: begin
        scl_oe_d = ~qtr_d[1];
        sda_oe_d = bit_low;
      end
      S_ACK: begin
        scl_oe_d = ~qtr_d[1];
        sda_oe_d = ack_low;
      end
      S_STOP: begin
        scl_oe_d = (qtr_d == 2'd0);
        sda_oe_d = ~qtr_d[1];
      end
      S_DONE: begin
        if (arb_event) begin
          scl_oe_d = 1'b0;
          sda_oe_d = 1'b0;
        end else if (state_q == S_ACK) begin
          scl_oe_d = 1'b1;
        end
      end
      default: begin
        scl_oe_d = scl_oe_q;
        sda_oe_d = sda_oe_q;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      qtr_q      <= 2'd0;
      bit_q      <= 3'd7;
      stop_q     <= 1'b0;
      read_q     <= 1'b0;
      nack_q     <= 1'b0;
      wdata_q    <= 8'h00;
      shift_q    <= 8'h00;
      ack_q      <= 1'b0;
      rd_data_q  <= 8'h00;
      rsp_nack_q <= 1'b0;
      arb_q      <= 1'b0;
      scl_oe_q   <= 1'b0;
      sda_oe_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      qtr_q      <= qtr_d;
      bit_q      <= bit_d;
      stop_q     <= stop_d;
      read_q     <= read_d;
      nack_q     <= nack_d;
      wdata_q    <= wdata_d;
      shift_q    <= shift_d;
      ack_q      <= ack_d;
      rd_data_q  <= rd_data_d;
      rsp_nack_q <= rsp_nack_d;
      arb_q      <= arb_d;
      scl_oe_q   <= scl_oe_d;
      sda_oe_q   <= sda_oe_d;
    end
  end

endmodule

// File: tb/tb_i2c_master_byte.sv
// Bench for i2c_master_byte: slave/arbiter pull-downs timed from acceptance, bus monitor, response scoreboard.
module tb_i2c_master_byte;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid, cmd_ready, cmd_start, cmd_stop, cmd_read, cmd_nack;
  logic [7:0] wr_data, rd_data;
  logic       rsp_valid, rsp_nack, rsp_arb_lost, busy, scl_oe, sda_oe;
  logic       slave_pull, arb_pull;
  logic       scl_bus, sda_bus;

  int n_vec = 0;
  int n_miss = 0;

  assign scl_bus = ~scl_oe;
  assign sda_bus = ~(sda_oe | slave_pull | arb_pull);

  always #5 clk = ~clk;

  i2c_master_byte #(.CLK_DIV(D)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_start(cmd_start), .cmd_stop(cmd_stop), .cmd_read(cmd_read), .cmd_nack(cmd_nack),
    .wr_data(wr_data), .rd_data(rd_data),
    .rsp_valid(rsp_valid), .rsp_nack(rsp_nack), .rsp_arb_lost(rsp_arb_lost),
    .busy(busy), .scl_oe(scl_oe), .sda_oe(sda_oe), .sda_in(sda_bus)
  );

  // Bus monitor: START/STOP edges and the SDA level at every SCL rise.
  int   start_cnt = 0;
  int   stop_cnt = 0;
  logic bits_q[$];
  logic scl_prev = 1'b1;
  logic sda_prev = 1'b1;

  always @(posedge clk) begin
    #1;
    if (scl_prev && scl_bus && sda_prev && !sda_bus) start_cnt++;
    if (scl_prev && scl_bus && !sda_prev && sda_bus) stop_cnt++;
    if (!scl_prev && scl_bus) bits_q.push_back(sda_bus);
    scl_prev = scl_bus;
    sda_prev = sda_bus;
  end

  typedef struct packed {
    logic [7:0]  rd;
    logic        nack;
    logic        arb;
    logic [15:0] lat;
  } exp_t;

  exp_t exp_q[$];

  function automatic int cmd_lat(input logic st, input logic sp);
    return 1 + (36 + (st ? 4 : 0) + (sp ? 4 : 0)) * D;
  endfunction

  function automatic logic [7:0] bits_byte(input int from);
    logic [7:0] b;
    b = 8'hxx;
    if (bits_q.size() >= from + 8) begin
      for (int i = 0; i < 8; i++) b[7-i] = bits_q[from+i];
    end
    return b;
  endfunction

  // Called at a negedge with cmd_ready high; returns at the negedge where rsp_valid is seen.
  // Slot k (0..7 data, 8 ACK) spans four phases; pat[8-k]=1 makes the slave pull SDA low in it.
  task automatic run_cmd(input logic st, input logic sp, input logic rd, input logic nk,
                         input logic [7:0] wd, input logic [8:0] pat, input int arb_slot,
                         output int lat, output logic [7:0] o_rd, output logic o_nack,
                         output logic o_arb, output logic rdy_c1, output logic ack_oe);
    int p;
    int slot;
    cmd_valid = 1'b1; cmd_start = st; cmd_stop = sp; cmd_read = rd; cmd_nack = nk; wr_data = wd;
    lat = -1; o_rd = 8'h00; o_nack = 1'b0; o_arb = 1'b0; rdy_c1 = 1'b1; ack_oe = 1'b0;
    for (int c = 1; c <= 1000; c++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      if (c == 1) rdy_c1 = cmd_ready;
      if (rsp_valid) begin
        lat = c; o_rd = rd_data; o_nack = rsp_nack; o_arb = rsp_arb_lost;
        break;
      end
      p = (c - 1) / D - (st ? 4 : 0);
      slot = (p >= 0 && p < 36) ? p / 4 : -1;
      if (slot == 8 && sda_oe) ack_oe = 1'b1;
      slave_pull = (slot >= 0) && pat[8-slot];
      arb_pull = (slot >= 0) && (slot == arb_slot);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++; if (scl_oe !== 1'b0) begin n_miss++; $display("FAIL reset_scl_oe: got %b want 0", scl_oe); end
    n_vec++; if (sda_oe !== 1'b0) begin n_miss++; $display("FAIL reset_sda_oe: got %b want 0", sda_oe); end
    n_vec++; if (cmd_ready !== 1'b1) begin n_miss++; $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready); end
    n_vec++; if (busy !== 1'b0) begin n_miss++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_vec++; if (rsp_valid !== 1'b0) begin n_miss++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
    n_vec++; if (rsp_nack !== 1'b0) begin n_miss++; $display("FAIL reset_rsp_nack: got %b want 0", rsp_nack); end
    n_vec++; if (rsp_arb_lost !== 1'b0) begin n_miss++; $display("FAIL reset_arb: got %b want 0", rsp_arb_lost); end
    n_vec++; if (rd_data !== 8'h00) begin n_miss++; $display("FAIL reset_rd_data: got %h want 00", rd_data); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_write_ack();
    exp_t e; int lat; logic [7:0] r; logic nk, ab, rdy, aoe; int s0, p0;
    bits_q.delete(); s0 = start_cnt; p0 = stop_cnt;
    e.rd = 8'h00; e.nack = 1'b0; e.arb = 1'b0; e.lat = 16'(cmd_lat(1'b1, 1'b1));
    exp_q.push_back(e);
    run_cmd(1'b1, 1'b1, 1'b0, 1'b0, 8'hA5, 9'b0_0000_0001, -1, lat, r, nk, ab, rdy, aoe);
    e = exp_q.pop_front();
    n_vec++; if (lat !== int'(e.lat)) begin n_miss++; $display("FAIL wr_latency: got %0d want %0d", lat, e.lat); end
    n_vec++; if (nk !== e.nack) begin n_miss++; $display("FAIL wr_nack: got %b want %b", nk, e.nack); end
    n_vec++; if (ab !== e.arb) begin n_miss++; $display("FAIL wr_arb: got %b want %b", ab, e.arb); end
    n_vec++; if (rdy !== 1'b0) begin n_miss++; $display("FAIL wr_ready_while_busy: got %b want 0", rdy); end
    repeat (2) @(negedge clk);
    n_vec++; if ({scl_oe, sda_oe} !== 2'b00) begin n_miss++; $display("FAIL wr_released: got %b want 00", {scl_oe, sda_oe}); end
    n_vec++; if (bits_byte(0) !== 8'hA5) begin n_miss++; $display("FAIL wr_sda_bits: got %h want a5", bits_byte(0)); end
    n_vec++; if (bits_q.size() < 9 || bits_q[8] !== 1'b0) begin n_miss++; $display("FAIL wr_ack_bit: size %0d, want ACK low", bits_q.size()); end
    n_vec++; if (start_cnt - s0 !== 1) begin n_miss++; $display("FAIL wr_start_cnt: got %0d want 1", start_cnt - s0); end
    n_vec++; if (stop_cnt - p0 !== 1) begin n_miss++; $display("FAIL wr_stop_cnt: got %0d want 1", stop_cnt - p0); end
  endtask

  task automatic test_no_start();
    exp_t e; int lat; logic [7:0] r; logic nk, ab, rdy, aoe; int s0;
    e.rd = 8'h00; e.nack = 1'b1; e.arb = 1'b0; e.lat = 16'(cmd_lat(1'b1, 1'b0));
    exp_q.push_back(e);
    run_cmd(1'b1, 1'b0, 1'b0, 1'b0, 8'h3C, 9'h000, -1, lat, r, nk, ab, rdy, aoe);
    e = exp_q.pop_front();
    n_vec++; if (lat !== int'(e.lat)) begin n_miss++; $display("FAIL nack_latency: got %0d want %0d", lat, e.lat); end
    n_vec++; if (nk !== e.nack) begin n_miss++; $display("FAIL nack_rsp_nack: got %b want %b", nk, e.nack); end
    repeat (3) @(negedge clk);
    n_vec++; if (scl_oe !== 1'b1) begin n_miss++; $display("FAIL nack_scl_held: got %b want 1", scl_oe); end
    s0 = start_cnt;
    e.rd = 8'h00; e.nack = 1'b0; e.arb = 1'b0; e.lat = 16'(cmd_lat(1'b0, 1'b1));
    exp_q.push_back(e);
    run_cmd(1'b0, 1'b1, 1'b0, 1'b0, 8'h5A, 9'h001, -1, lat, r, nk, ab, rdy, aoe);
    e = exp_q.pop_front();
    n_vec++; if (lat !== int'(e.lat)) begin n_miss++; $display("FAIL nostart_latency: got %0d want %0d", lat, e.lat); end
    n_vec++; if (nk !== e.nack) begin n_miss++; $display("FAIL nostart_nack: got %b want %b", nk, e.nack); end
    n_vec++; if (start_cnt !== s0) begin n_miss++; $display("FAIL nostart_edges: got %0d want 0", start_cnt - s0); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_read();
    exp_t e; int lat; logic [7:0] r; logic nk, ab, rdy, aoe;
    bits_q.delete();
    e.rd = 8'hC3; e.nack = 1'b1; e.arb = 1'b0; e.lat = 16'(cmd_lat(1'b1, 1'b1));
    exp_q.push_back(e);
    run_cmd(1'b1, 1'b1, 1'b1, 1'b1, 8'h00, {8'h3C, 1'b0}, -1, lat, r, nk, ab, rdy, aoe);
    e = exp_q.pop_front();
    n_vec++; if (lat !== int'(e.lat)) begin n_miss++; $display("FAIL rd_latency: got %0d want %0d", lat, e.lat); end
    n_vec++; if (r !== e.rd) begin n_miss++; $display("FAIL rd_data: got %h want %h", r, e.rd); end
    n_vec++; if (nk !== e.nack) begin n_miss++; $display("FAIL rd_nack: got %b want %b", nk, e.nack); end
    n_vec++; if (aoe !== 1'b0) begin n_miss++; $display("FAIL rd_ack_sda_oe: got %b want 0", aoe); end
    n_vec++; if (bits_byte(0) !== 8'hC3) begin n_miss++; $display("FAIL rd_bus_bits: got %h want c3", bits_byte(0)); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_arbitration();
    exp_t e; int lat; logic [7:0] r; logic nk, ab, rdy, aoe; int p0;
    bits_q.delete(); p0 = stop_cnt;
    e.rd = 8'h00; e.nack = 1'b0; e.arb = 1'b1; e.lat = 16'(1 + (4 + 4 * 2 + 3) * D);
    exp_q.push_back(e);
    run_cmd(1'b1, 1'b1, 1'b0, 1'b0, 8'hFF, 9'h000, 2, lat, r, nk, ab, rdy, aoe);
    e = exp_q.pop_front();
    n_vec++; if (lat !== int'(e.lat)) begin n_miss++; $display("FAIL arb_latency: got %0d want %0d", lat, e.lat); end
    n_vec++; if (ab !== e.arb) begin n_miss++; $display("FAIL arb_flag: got %b want %b", ab, e.arb); end
    n_vec++; if (nk !== e.nack) begin n_miss++; $display("FAIL arb_nack: got %b want %b", nk, e.nack); end
    n_vec++; if ({scl_oe, sda_oe} !== 2'b00) begin n_miss++; $display("FAIL arb_released: got %b want 00", {scl_oe, sda_oe}); end
    n_vec++; if (bits_q.size() !== 3) begin n_miss++; $display("FAIL arb_scl_pulses: got %0d want 3", bits_q.size()); end
    repeat (4) @(negedge clk);
    n_vec++; if (stop_cnt !== p0 || scl_oe !== 1'b0) begin n_miss++; $display("FAIL arb_no_stop: stops %0d scl_oe %b want 0 0", stop_cnt - p0, scl_oe); end
    arb_pull = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    exp_t e; int lat; logic [7:0] r; logic nk, ab, rdy, aoe; int s0, p0;
    bits_q.delete(); s0 = start_cnt; p0 = stop_cnt;
    e.rd = 8'h00; e.nack = 1'b0; e.arb = 1'b0; e.lat = 16'(cmd_lat(1'b1, 1'b0));
    exp_q.push_back(e);
    e.lat = 16'(cmd_lat(1'b1, 1'b1));
    exp_q.push_back(e);
    run_cmd(1'b1, 1'b0, 1'b0, 1'b0, 8'h11, 9'h001, -1, lat, r, nk, ab, rdy, aoe);
    e = exp_q.pop_front();
    n_vec++; if (lat !== int'(e.lat) || nk !== e.nack) begin n_miss++; $display("FAIL b2b_first: lat %0d nack %b want %0d %b", lat, nk, e.lat, e.nack); end
    run_cmd(1'b1, 1'b1, 1'b0, 1'b0, 8'h22, 9'h001, -1, lat, r, nk, ab, rdy, aoe);
    e = exp_q.pop_front();
    n_vec++; if (lat !== int'(e.lat) || nk !== e.nack) begin n_miss++; $display("FAIL b2b_second: lat %0d nack %b want %0d %b", lat, nk, e.lat, e.nack); end
    repeat (2) @(negedge clk);
    n_vec++; if (start_cnt - s0 !== 2) begin n_miss++; $display("FAIL rstart_count: got %0d want 2", start_cnt - s0); end
    n_vec++; if (stop_cnt - p0 !== 1) begin n_miss++; $display("FAIL rstart_stop_count: got %0d want 1", stop_cnt - p0); end
    n_vec++; if (bits_byte(10) !== 8'h22) begin n_miss++; $display("FAIL rstart_second_byte: got %h want 22", bits_byte(10)); end
  endtask

  task automatic test_reset_mid();
    exp_t e; int lat; logic [7:0] r; logic nk, ab, rdy, aoe; logic saw_rsp;
    cmd_valid = 1'b1; cmd_start = 1'b1; cmd_stop = 1'b1; cmd_read = 1'b0; cmd_nack = 1'b0; wr_data = 8'h96;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (85) @(negedge clk);
    n_vec++; if ({scl_oe, busy} !== 2'b11) begin n_miss++; $display("FAIL mid_pre_reset: scl_oe,busy got %b want 11", {scl_oe, busy}); end
    rst_n = 1'b0;
    #1;
    n_vec++; if ({scl_oe, sda_oe, busy} !== 3'b000) begin n_miss++; $display("FAIL mid_reset_lines: got %b want 000", {scl_oe, sda_oe, busy}); end
    saw_rsp = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (rsp_valid) saw_rsp = 1'b1;
    end
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (rsp_valid) saw_rsp = 1'b1;
    end
    n_vec++; if (saw_rsp !== 1'b0) begin n_miss++; $display("FAIL mid_no_rsp: got %b want 0", saw_rsp); end
    n_vec++; if (cmd_ready !== 1'b1) begin n_miss++; $display("FAIL mid_ready_after: got %b want 1", cmd_ready); end
    e.rd = 8'h00; e.nack = 1'b0; e.arb = 1'b0; e.lat = 16'(cmd_lat(1'b1, 1'b1));
    exp_q.push_back(e);
    run_cmd(1'b1, 1'b1, 1'b0, 1'b0, 8'h96, 9'h001, -1, lat, r, nk, ab, rdy, aoe);
    e = exp_q.pop_front();
    n_vec++; if (lat !== int'(e.lat) || nk !== e.nack) begin n_miss++; $display("FAIL mid_recover: lat %0d nack %b want %0d %b", lat, nk, e.lat, e.nack); end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_start = 1'b0; cmd_stop = 1'b0;
    cmd_read = 1'b0; cmd_nack = 1'b0; wr_data = 8'h00;
    slave_pull = 1'b0; arb_pull = 1'b0;
    test_reset();
    test_write_ack();
    test_no_start();
    test_read();
    test_arbitration();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
